// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the CPU data port, the debug/loader port and the
// data-memory port that meet at mem_arbiter.
//   slave  modport : the arbiter side (takes requests, drives memory + acks)
//   master modport : the requester/memory side (testbench, pipeline, RAM)
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // CPU data port
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_stall;
  // debug/loader port
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_ack;
  // data memory port
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  // status
  logic              busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous data memory between the
// CPU data port and a debug/loader port.
//
// Every access walks IDLE -> ISSUE -> ACK (one cycle each), so the arbiter
// completes one access every 3 cycles. Requests are only looked at in IDLE.
// CPU wins contention, but after MAX_WAIT consecutive lost arbitrations the
// debug port is forced through so it cannot starve.
//
// Ports:
//   clk    : clock, all state on rising edge
//   reset  : synchronous, active-high
//   bus    : mem_arbiter_if.slave
//            cpu_*  : CPU request/ack/rdata, cpu_stall to hazard logic
//            dbg_*  : debug request/ack/rdata
//            mem_*  : memory enable/we/addr/wdata out, mem_rdata in
//            busy   : high whenever the FSM is not in IDLE
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic           clk,
  input  logic           reset,
  mem_arbiter_if.slave   bus
);

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WMAX = WCW'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;
  typedef enum logic {OWN_CPU, OWN_DBG} owner_t;

  // Registered access driven onto the memory port for the whole transaction.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_t;

  state_t          state_q, state_d;
  owner_t          owner_q, owner_d;
  acc_t            acc_q, acc_d;
  logic [WCW-1:0]  wait_cnt, wait_d;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;

  // Debug wins if it is alone, or if it has already lost MAX_WAIT times.
  logic dbg_win;
  assign dbg_win = bus.dbg_req && (!bus.cpu_req || (wait_cnt == WMAX));

  // ---------------------------------------------------------------------
  // next-state / grant logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    acc_d   = acc_q;
    wait_d  = wait_cnt;
    unique case (state_q)
      IDLE: begin
        if (dbg_win) begin
          owner_d = OWN_DBG;
          acc_d   = '{we: bus.dbg_we, addr: bus.dbg_addr, wdata: bus.dbg_wdata};
          wait_d  = '0;
          state_d = ISSUE;
        end else if (bus.cpu_req) begin
          owner_d = OWN_CPU;
          acc_d   = '{we: bus.cpu_we, addr: bus.cpu_addr, wdata: bus.cpu_wdata};
          // Only a lost arbitration counts; a lone CPU request resets the
          // streak because debug was not waiting.
          if (!bus.dbg_req)
            wait_d = '0;
          else if (wait_cnt < WMAX)
            wait_d = WCW'(wait_cnt + 1'b1);
          state_d = ISSUE;
        end else begin
          wait_d = '0;
        end
      end
      ISSUE:   state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // state, access and read-data registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      acc_q       <= '0;
      wait_cnt    <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      acc_q    <= acc_d;
      wait_cnt <= wait_d;
      // Read data is valid at the edge closing the ISSUE cycle; only the
      // owner's register moves, writes leave both untouched.
      if (state_q == ISSUE && !acc_q.we) begin
        if (owner_q == OWN_CPU) cpu_rdata_q <= bus.mem_rdata;
        else                    dbg_rdata_q <= bus.mem_rdata;
      end
    end
  end

  // ---------------------------------------------------------------------
  // outputs
  // ---------------------------------------------------------------------
  // mem_en comes straight from the state register, so an access already in
  // ISSUE still hits memory even if reset is asserted in that cycle.
  assign bus.mem_en    = (state_q == ISSUE);
  assign bus.mem_we    = (state_q == ISSUE) && acc_q.we;
  assign bus.mem_addr  = acc_q.addr;
  assign bus.mem_wdata = acc_q.wdata;

  assign bus.cpu_ack   = (state_q == ACK) && (owner_q == OWN_CPU);
  assign bus.dbg_ack   = (state_q == ACK) && (owner_q == OWN_DBG);
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dbg_rdata = dbg_rdata_q;

  // Stall covers cycles spent behind a debug access too.
  assign bus.cpu_stall = bus.cpu_req && !bus.cpu_ack;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected acks
// (owner + read data) into a queue, a negedge monitor pops and compares.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- memory model (async read, sync write) ----------------
  logic [31:0] mem [0:255];
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_dat;

  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];
  always @(posedge clk) begin
    if (pl_en)                       mem[pl_idx] <= pl_dat;
    else if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          dbg;
    logic [31:0] data;
  } exp_t;
  exp_t sbq[$];

  int total = 0;
  int bad   = 0;

  task automatic push(input bit d, input logic [31:0] v);
    exp_t e;
    e.dbg = d; e.data = v;
    sbq.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  bit prev_c = 0, prev_d = 0;
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] got;
    if (!reset && (bus.cpu_ack || bus.dbg_ack)) begin
      total++;
      if (bus.cpu_ack && bus.dbg_ack) begin
        bad++; $display("FAIL both_acks: cpu_ack=1 dbg_ack=1 want one");
      end
      total++;
      if ((bus.cpu_ack && prev_c) || (bus.dbg_ack && prev_d)) begin
        bad++; $display("FAIL ack_width: ack high two cycles, want one");
      end
      total++;
      if (sbq.size() == 0) begin
        bad++; $display("FAIL unexpected_ack: cpu=%0b dbg=%0b with empty queue", bus.cpu_ack, bus.dbg_ack);
      end else begin
        e = sbq.pop_front();
        if (bus.dbg_ack != e.dbg) begin
          bad++; $display("FAIL ack_owner: got dbg=%0b want dbg=%0b", bus.dbg_ack, e.dbg);
        end else begin
          got = e.dbg ? bus.dbg_rdata : bus.cpu_rdata;
          total++;
          if (got !== e.data) begin
            bad++; $display("FAIL ack_rdata: got %0h want %0h", got, e.data);
          end
        end
      end
    end
    prev_c = bus.cpu_ack;
    prev_d = bus.dbg_ack;
  end

  // ---------------- helpers ----------------
  task automatic preload(input logic [7:0] idx, input logic [31:0] v);
    @(negedge clk); pl_en = 1; pl_idx = idx; pl_dat = v;
    @(negedge clk); pl_en = 0;
  endtask

  task automatic wait_ack(input bit d, input int lim, input string nm);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (d ? bus.dbg_ack : bus.cpu_ack) return;
    end
    total++; bad++;
    $display("FAIL %s: got no ack within %0d cycles want ack", nm, lim);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] b2b_addr [3];
    logic [31:0] b2b_data [3];
    bit seen;
    b2b_addr = '{32'h10, 32'h14, 32'h18};
    b2b_data = '{32'hDEADBEEF, 32'h11111111, 32'h22222222};

    reset = 1; pl_en = 0; pl_idx = 0; pl_dat = 0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = 0; bus.dbg_wdata = 0;

    preload(8'd4,  32'hDEADBEEF);   // 0x10
    preload(8'd5,  32'h11111111);   // 0x14
    preload(8'd6,  32'h22222222);   // 0x18
    preload(8'd16, 32'hC0C00001);   // 0x40
    preload(8'd17, 32'hD0D00002);   // 0x44

    // reset state
    @(negedge clk);
    chk("rst_mem_en",  bus.mem_en, 0);
    chk("rst_mem_we",  bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_acks",    {bus.cpu_ack, bus.dbg_ack}, 0);
    chk("rst_rdata",   {bus.cpu_rdata, bus.dbg_rdata}, 0);
    chk("rst_busy",    bus.busy, 0);
    chk("rst_wait_cnt", dut.wait_cnt, 0);
    reset = 0;

    // CPU read of 0x10
    @(negedge clk);
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h10;
    push(0, 32'hDEADBEEF);
    #1;
    chk("rd_c1_stall", bus.cpu_stall, 1);
    chk("rd_c1_mem_en", bus.mem_en, 0);
    @(negedge clk);
    chk("rd_c2_mem_en", bus.mem_en, 1);
    chk("rd_c2_addr",  bus.mem_addr, 32'h10);
    chk("rd_c2_we",    bus.mem_we, 0);
    chk("rd_c2_stall", bus.cpu_stall, 1);
    @(negedge clk);
    chk("rd_c3_ack",   bus.cpu_ack, 1);
    chk("rd_c3_stall", bus.cpu_stall, 0);
    chk("rd_c3_mem_en", bus.mem_en, 0);
    bus.cpu_req = 0;

    // debug write 0x20, then CPU read it back
    @(negedge clk);
    bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 32'h20; bus.dbg_wdata = 32'h12345678;
    push(1, 32'h0);
    wait_ack(1, 10, "dbg_wr_ack");
    bus.dbg_req = 0; bus.dbg_we = 0;
    chk("dbg_wr_mem", mem[8], 32'h12345678);
    @(negedge clk);
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h20;
    push(0, 32'h12345678);
    wait_ack(0, 10, "cpu_rd20_ack");
    bus.cpu_req = 0;
    chk("dbg_rdata_hold", bus.dbg_rdata, 0);

    // back-to-back CPU reads, mem_en every 3 cycles
    @(negedge clk);
    bus.cpu_req = 1; bus.cpu_addr = b2b_addr[0];
    for (int k = 0; k < 3; k++) push(0, b2b_data[k]);
    seen = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      seen = bus.mem_en;
    end
    chk("b2b_first_en", seen, 1);
    for (int k = 0; k < 3; k++) begin
      chk("b2b_issue_en",   bus.mem_en, 1);
      chk("b2b_issue_busy", bus.busy, 1);
      chk("b2b_issue_addr", bus.mem_addr, b2b_addr[k]);
      @(negedge clk);
      chk("b2b_ack_en",   bus.mem_en, 0);
      chk("b2b_ack",      bus.cpu_ack, 1);
      chk("b2b_ack_busy", bus.busy, 1);
      if (k < 2) bus.cpu_addr = b2b_addr[k+1];
      else       bus.cpu_req = 0;
      @(negedge clk);
      chk("b2b_idle_en",   bus.mem_en, 0);
      chk("b2b_idle_busy", bus.busy, 0);
      @(negedge clk);
    end

    // contention: both held, MAX_WAIT=4 -> C C C C D C C C C D, then lone C
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h40;
    bus.dbg_req = 1; bus.dbg_we = 0; bus.dbg_addr = 32'h44;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) push(0, 32'hC0C00001);
      push(1, 32'hD0D00002);
    end
    push(0, 32'hC0C00001);
    wait_ack(1, 30, "cont_dbg1");
    wait_ack(1, 30, "cont_dbg2");
    bus.dbg_req = 0;
    wait_ack(0, 10, "cont_cpu_last");
    bus.cpu_req = 0;
    @(negedge clk);
    chk("cont_wait_cnt", dut.wait_cnt, 0);

    // reset during ISSUE of a CPU write to 0x30
    @(negedge clk);
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 32'h30; bus.cpu_wdata = 32'hA5A55A5A;
    @(negedge clk);
    chk("rmid_issue_en", bus.mem_en, 1);
    chk("rmid_issue_we", bus.mem_we, 1);
    reset = 1; bus.cpu_req = 0; bus.cpu_we = 0;
    @(negedge clk);
    reset = 0;
    chk("rmid_mem_written", mem[12], 32'hA5A55A5A);
    chk("rmid_mem_en",   bus.mem_en, 0);
    chk("rmid_mem_we",   bus.mem_we, 0);
    chk("rmid_mem_addr", bus.mem_addr, 0);
    chk("rmid_mem_wdata", bus.mem_wdata, 0);
    chk("rmid_cpu_rdata", bus.cpu_rdata, 0);
    chk("rmid_dbg_rdata", bus.dbg_rdata, 0);
    chk("rmid_busy",     bus.busy, 0);
    chk("rmid_acks",     {bus.cpu_ack, bus.dbg_ack}, 0);
    repeat (3) begin
      @(negedge clk);
      chk("rmid_no_ack", bus.cpu_ack, 0);
    end

    // idle stability
    repeat (10) begin
      @(negedge clk);
      chk("idle_mem_en", bus.mem_en, 0);
      chk("idle_acks",   {bus.cpu_ack, bus.dbg_ack}, 0);
      chk("idle_busy",   bus.busy, 0);
      chk("idle_wait",   dut.wait_cnt, 0);
    end

    chk("sb_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port synchronous data memory between the CPU data port and a debug/loader port, so programs and data can be loaded or inspected while the pipeline runs.
- Sits between the pipeline's EX-stage memory access and the data memory.
- Sequences every access through a fixed 3-state FSM and drives a stall to the CPU hazard logic while a CPU access is outstanding.
- CPU has priority; a starvation counter guarantees debug progress.

Parameters:
ADDR_W, 32, address width of both ports and memory
DATA_W, 32, data width of both ports and memory
MAX_WAIT, 4, consecutive lost arbitrations before debug is forced to win (legal range 1..15)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request; held until cpu_ack
cpu_we  in  1  CPU write enable (0 = read)
cpu_addr  in  ADDR_W  CPU byte address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  CPU read data; valid in the cpu_ack cycle
cpu_ack  out  1  one-cycle completion pulse to CPU
cpu_stall  out  1  cpu_req & ~cpu_ack (combinational), to hazard logic
dbg_req  in  1  debug access request; held until dbg_ack
dbg_we  in  1  debug write enable
dbg_addr  in  ADDR_W  debug address
dbg_wdata  in  DATA_W  debug write data
dbg_rdata  out  DATA_W  debug read data; valid in the dbg_ack cycle
dbg_ack  out  1  one-cycle completion pulse to debug
mem_en  out  1  memory enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data; valid at the edge ending the mem_en cycle
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values:
  - state = IDLE.
  - All outputs 0: mem_en, mem_we, mem_addr, mem_wdata, cpu_ack, dbg_ack, cpu_rdata, dbg_rdata.
  - wait_cnt = 0; owner = CPU.
- FSM states: IDLE, ISSUE, ACK.
- IDLE:
  - Requests are sampled only in IDLE.
  - If any request is high, choose a winner, register its we/addr/wdata into mem_* and its identity into owner, then go to ISSUE.
  - If no request is high, stay in IDLE.
- Arbitration in IDLE:
  - Only one requester high: that requester wins.
  - Both high, wait_cnt < MAX_WAIT: CPU wins and wait_cnt increments.
  - Both high, wait_cnt == MAX_WAIT: debug wins.
  - wait_cnt clears when debug is granted or when dbg_req is low in IDLE.
  - wait_cnt saturates and never exceeds MAX_WAIT.
- ISSUE (exactly one cycle):
  - mem_en = 1; mem_we/addr/wdata hold the registered values.
  - At the closing edge, on a read, capture mem_rdata into the owner's rdata register.
  - The non-owner's rdata holds its value. Write accesses leave both rdata registers unchanged.
  - Go to ACK.
- ACK (exactly one cycle):
  - mem_en = 0 and mem_we = 0.
  - The owner's ack = 1; all other acks = 0.
  - Requests are ignored; next state is IDLE.
- Latency: request first seen in IDLE at edge N → mem_en high in cycle N+1 → ack and rdata valid in cycle N+2.
- Throughput: one access every 3 cycles per arbiter.
- Requester handshake: a requester must hold req, we, addr and wdata stable until its ack, and drop req in the cycle after ack. A req still high in IDLE after ack is a new request.
- Debug control inputs are ignored while the CPU owns the access, and vice versa; changing them has no effect.
- cpu_stall is high in every cycle where cpu_req = 1 and cpu_ack = 0, including cycles spent waiting on a debug access.
- Reset mid-operation:
  - If reset is high during ISSUE, the memory operation in that cycle still occurs, because mem_en is already driven.
  - No ack is produced; state returns to IDLE and all registers return to their reset values at that edge.
- wait_cnt is ceil(log2(MAX_WAIT+1)) bits wide; no other arithmetic.

Test Plan:
- CPU read only: preload mem[0x10]=0xDEADBEEF; cpu_req=1, we=0, addr=0x10 at cycle 1 → mem_en=1 in cycle 2; cpu_ack=1 with cpu_rdata=0xDEADBEEF in cycle 3; cpu_stall=1 in cycles 1-2 and 0 in cycle 3.
- Debug write then CPU read: dbg write 0x20←0x12345678; after dbg_ack, CPU reads 0x20 → cpu_rdata=0x12345678; dbg_rdata unchanged (0).
- Contention, MAX_WAIT=4: both req held continuously → first 4 grants go to CPU, the 5th to debug, and wait_cnt returns to 0; every ack pulse is exactly one cycle and never both acks at once.
- Back-to-back CPU: cpu_req re-raised the cycle after each ack → successive mem_en pulses exactly 3 cycles apart; busy low only in the IDLE cycles.
- Reset during ISSUE of a CPU write to 0x30: memory holds the written value, no cpu_ack appears, and all outputs are 0 the following cycle.
- Idle stability: no requests for 10 cycles → mem_en, both acks and busy stay 0, and wait_cnt stays 0.
